// File: rtl/fibonacci_shared_adder_pkg.sv
// Shared constants and state encodings for the breathing-PWM Fibonacci generator.
package fibonacci_shared_adder_pkg;
  localparam int PWM_W    = 8;
  localparam int FIB_W    = 9;
  localparam int TOP_TERM = 233;

  typedef enum logic {PH_COUNT, PH_UPDATE} phase_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/fibonacci_shared_adder_fib_shared_add.sv
// The single W-bit adder (A + B + cin) shared by every arithmetic step of the top.
module fib_shared_add #(
  parameter int W = 9
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  assign sum = op_a + op_b + {{(W-1){1'b0}}, cin};
endmodule

// File: rtl/fibonacci_shared_adder.sv
// Breathing PWM: duty walks the Fibonacci terms up to TOP_TERM and back down,
// one term per 257-cycle frame, with all arithmetic time-shared on one adder.
module fibonacci_shared_adder
  import fibonacci_shared_adder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pwm_out
);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;
  localparam logic [FIB_W-1:0] TOP_A   = FIB_W'(TOP_TERM);
  localparam logic [FIB_W-1:0] ONE     = FIB_W'(1);

  logic [PWM_W-1:0] count_q, count_d;
  phase_t           phase_q, phase_d;
  dir_t             dir_q, dir_d;
  logic [FIB_W-1:0] a_q, a_d, b_q, b_d;
  logic             pwm_q, pwm_d;

  logic [FIB_W-1:0] op_a, op_b, sum, count_ext;
  logic             cin;

  assign count_ext = {{(FIB_W-PWM_W){1'b0}}, count_q};

  // Operand steering: increment count, add the pair, or subtract a from b (b + ~a + 1).
  always_comb begin
    op_a = count_ext;
    op_b = '0;
    cin  = 1'b1;
    if (phase_q == PH_UPDATE) begin
      if (dir_q == DIR_UP) begin
        op_a = a_q;
        op_b = b_q;
        cin  = 1'b0;
      end else begin
        op_a = b_q;
        op_b = ~a_q;
        cin  = 1'b1;
      end
    end
  end

  fib_shared_add #(.W(FIB_W)) u_add (
    .op_a (op_a),
    .op_b (op_b),
    .cin  (cin),
    .sum  (sum)
  );

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    a_d     = a_q;
    b_d     = b_q;
    pwm_d   = 1'b0;
    if (en) begin
      if (phase_q == PH_COUNT) begin
        pwm_d   = (count_ext < a_q);
        count_d = sum[PWM_W-1:0];
        if (count_q == CNT_MAX) phase_d = PH_UPDATE;
      end else begin
        if (dir_q == DIR_UP) begin
          a_d = b_q;
          b_d = sum;
        end else begin
          a_d = sum;
          b_d = a_q;
        end
        // Turn around at the top term, and again once the pair collapses back to (1,1).
        if (a_d == TOP_A)                   dir_d = DIR_DOWN;
        else if (a_d == ONE && b_d == ONE)  dir_d = DIR_UP;
        count_d = '0;
        phase_d = PH_COUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_COUNT;
      dir_q   <= DIR_UP;
      a_q     <= ONE;
      b_q     <= ONE;
      pwm_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
endmodule

// File: tb/tb_fibonacci_shared_adder.sv
// Self-checking bench: frame-position reference model of the breathing PWM.
module tb_fibonacci_shared_adder;
  import fibonacci_shared_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pwm_out;

  int tests = 0;
  int fails = 0;
  int m_frame = 0;
  int m_pos = 0;

  fibonacci_shared_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Pulse width of frame k: Fibonacci terms up to 233 and mirrored back, period 24.
  function automatic int exp_width(input int k);
    int fib[13];
    int idx;
    fib[0] = 1;
    fib[1] = 1;
    for (int i = 2; i < 13; i++) fib[i] = fib[i-1] + fib[i-2];
    idx = k % 24;
    if (idx > 12) idx = 24 - idx;
    return fib[idx];
  endfunction

  task automatic tick(input bit e, output logic p, output logic x);
    en = e;
    @(posedge clk);
    #1;
    p = pwm_out;
    if (e) begin
      x = (m_pos < exp_width(m_frame));
      m_pos++;
      if (m_pos == 257) begin
        m_pos = 0;
        m_frame++;
      end
    end else begin
      x = 1'b0;
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_frame = 0;
    m_pos = 0;
  endtask

  task automatic run_frame(output int width, output int first_hi, output int last_hi);
    logic p, x;
    width = 0;
    first_hi = -1;
    last_hi = -1;
    for (int i = 0; i < 257; i++) begin
      tick(1'b1, p, x);
      if (p === 1'b1) begin
        width++;
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (dut.phase_q == PH_UPDATE && pwm_out === 1'b1) begin
        fails++;
        $display("FAIL pwm_in_update: pwm_out=%b in UPDATE, required 0", pwm_out);
      end
      tests++;
      if (dut.a_q > 9'(TOP_TERM)) begin
        fails++;
        $display("FAIL a_bound: a=%0d, required <= %0d", dut.a_q, TOP_TERM);
      end
    end
  end

  task automatic test_reset();
    logic p, x;
    en = 1'b1;
    rst_n = 1'b0;
    #13;
    tests++;
    if (pwm_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_pwm: got %b, required 0", pwm_out);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, p, x);
      tests++;
      if (p !== 1'b0) begin
        fails++;
        $display("FAIL idle_after_reset: cycle %0d got %b, required 0", i, p);
      end
    end
  endtask

  task automatic test_first_frames();
    int w, f, l;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_frame(w, f, l);
      tests++;
      if (w !== exp_width(k) || f !== 0) begin
        fails++;
        $display("FAIL first_frames[%0d]: width %0d rise@%0d, required width %0d rise@0 (257*k apart)",
                 k, w, f, exp_width(k));
      end
    end
  endtask

  task automatic test_free_run();
    int w, f, l;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      run_frame(w, f, l);
      tests++;
      if (w !== exp_width(k) || f !== 0 || l !== exp_width(k) - 1) begin
        fails++;
        $display("FAIL free_run[%0d]: width %0d first %0d last %0d, required width %0d first 0 last %0d",
                 k, w, f, l, exp_width(k), exp_width(k) - 1);
      end
    end
  endtask

  task automatic test_pause();
    logic p, x;
    int w, f, l, highs;
    do_reset();
    for (int k = 0; k < 8; k++) run_frame(w, f, l);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, p, x);
      if (p === 1'b1) highs++;
    end
    tests++;
    if (p !== 1'b1) begin
      fails++;
      $display("FAIL pause_pre: pwm %b before pause, required 1", p);
    end
    tick(1'b0, p, x);
    tests++;
    if (p !== 1'b0) begin
      fails++;
      $display("FAIL pause_drop: pwm %b one cycle after en=0, required 0", p);
    end
    w = 0;
    for (int i = 0; i < 99; i++) begin
      tick(1'b0, p, x);
      if (p !== 1'b0) w++;
    end
    tests++;
    if (w != 0) begin
      fails++;
      $display("FAIL pause_hold: %0d high cycles while paused, required 0", w);
    end
    for (int i = 10; i < 257; i++) begin
      tick(1'b1, p, x);
      if (p === 1'b1) highs++;
    end
    tests++;
    if (highs != exp_width(8)) begin
      fails++;
      $display("FAIL pause_resume: frame width %0d, required %0d", highs, exp_width(8));
    end
    run_frame(w, f, l);
    tests++;
    if (w != exp_width(9) || f != 0) begin
      fails++;
      $display("FAIL pause_next: width %0d first %0d, required %0d first 0", w, f, exp_width(9));
    end
  endtask

  task automatic test_random_enable();
    logic p, x;
    do_reset();
    for (int i = 0; i < 2600; i++) begin
      tick($urandom_range(0, 3) != 0, p, x);
      tests++;
      if (p !== x) begin
        fails++;
        $display("FAIL random_en: cycle %0d frame %0d got %b, required %b", i, m_frame, p, x);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic p, x;
    int w, f, l;
    do_reset();
    for (int k = 0; k < 12; k++) run_frame(w, f, l);
    for (int i = 0; i < 100; i++) tick(1'b1, p, x);
    tests++;
    if (p !== 1'b1 || exp_width(12) != 233) begin
      fails++;
      $display("FAIL top_frame: pwm %b in frame 12, required 1 (width 233)", p);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (pwm_out !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: pwm %b right after rst_n=0, required 0", pwm_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_frame = 0;
    m_pos = 0;
    for (int k = 0; k < 3; k++) begin
      run_frame(w, f, l);
      tests++;
      if (w !== exp_width(k) || f !== 0) begin
        fails++;
        $display("FAIL restart[%0d]: width %0d first %0d, required %0d first 0", k, w, f, exp_width(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_free_run();
    test_pause();
    test_random_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
